// File: rtl/counter_pkg.sv
// counter_pkg: shared FSM state encoding and load-value saturation for the counter family
//   state_t  : IDLE / RUN / PAUSE / EXPIRED encoding used by countdown_timer
//   sat_max  : returns min(v, m), used to clamp load values to MAX_LOAD
package counter_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      RUN     = 2'd1,
      PAUSE   = 2'd2,
      EXPIRED = 2'd3
   } state_t;

   function automatic logic [31:0] sat_max(input logic [31:0] v, input logic [31:0] m);
      return (v > m) ? m : v;
   endfunction

endpackage

// File: rtl/tick_prescaler.sv
// tick_prescaler: TICK_DIV modulo counter that emits a one-cycle tick on wrap
//   clk   in  rising-edge clock
//   rst_n in  asynchronous reset, active low
//   clr   in  synchronous clear of the phase counter (has priority over en)
//   en    in  advance the phase counter this cycle; when low the phase is held
//   tick  out high in the enabled cycle where the counter wraps (equals en when TICK_DIV=1)
module tick_prescaler #(
   parameter int TICK_DIV = 1
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clr,
   input  logic en,
   output logic tick
);

   localparam int W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

   logic [W-1:0] r_phase;
   logic         w_wrap;

   // With TICK_DIV=1 the terminal value is 0, so every enabled cycle wraps
   assign w_wrap = (r_phase == W'(TICK_DIV - 1));
   assign tick   = en && w_wrap;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         r_phase <= '0;
      else
         r_phase <= clr ? '0 : en ? (w_wrap ? '0 : r_phase + W'(1)) : r_phase;
   end

endmodule

// File: rtl/countdown_timer.sv
// countdown_timer: loadable saturating down-counter with pause/resume and expiry pulse
//   clk      in   rising-edge clock
//   rst_n    in   asynchronous reset, active low
//   load     in   load min(load_val, MAX_LOAD) into cnt and return to IDLE
//   load_val in   value to load
//   start    in   begin counting from IDLE (cnt!=0) or resume from PAUSE
//   pause    in   freeze counting while in RUN
//   cnt      out  current count
//   busy     out  high while in RUN
//   zero     out  high when cnt == 0
//   done     out  one-cycle pulse on the cycle cnt has just reached 0 from RUN
module countdown_timer #(
   parameter int WIDTH    = 7,
   parameter int MAX_LOAD = 100,
   parameter int TICK_DIV = 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   input  logic             start,
   input  logic             pause,
   output logic [WIDTH-1:0] cnt,
   output logic             busy,
   output logic             zero,
   output logic             done
);

   import counter_pkg::*;

   state_t           r_state;
   state_t           w_state_nxt;
   logic [WIDTH-1:0] r_cnt;
   logic [WIDTH-1:0] w_cnt_nxt;
   logic [WIDTH-1:0] w_load_sat;
   logic             r_busy;
   logic             r_zero;
   logic             r_done;
   logic             w_done_nxt;
   logic             w_tick;
   logic             w_pre_clr;
   logic             w_pre_en;

   assign w_load_sat = WIDTH'(sat_max(32'(load_val), 32'(MAX_LOAD)));

   // Phase restarts on load and on a fresh start; pause simply stops it so a
   // resume continues from the held phase with no lost or extra cycles
   assign w_pre_clr = load || (r_state == IDLE && start && !pause);
   assign w_pre_en  = (r_state == RUN) && !load && !pause;

   tick_prescaler #(
      .TICK_DIV(TICK_DIV)
   ) u_prescaler (
      .clk  (clk),
      .rst_n(rst_n),
      .clr  (w_pre_clr),
      .en   (w_pre_en),
      .tick (w_tick)
   );

   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_done_nxt  = 1'b0;
      if (load) begin
         w_cnt_nxt   = w_load_sat;
         w_state_nxt = IDLE;
      end else begin
         case (r_state)
            IDLE:    w_state_nxt = (start && !pause && r_cnt != '0) ? RUN : IDLE;
            RUN: begin
               if (pause)
                  w_state_nxt = PAUSE;
               else if (w_tick) begin
                  // <= 1 rather than == 1 so a corrupted zero count still expires
                  w_cnt_nxt   = (r_cnt <= WIDTH'(1)) ? '0 : r_cnt - WIDTH'(1);
                  w_state_nxt = (r_cnt <= WIDTH'(1)) ? EXPIRED : RUN;
                  w_done_nxt  = (r_cnt <= WIDTH'(1));
               end
            end
            PAUSE:   w_state_nxt = (start && !pause) ? RUN : PAUSE;
            default: w_state_nxt = EXPIRED;
         endcase
      end
   end

   // Flags are registered from the next-state values so they change on the
   // same edge as state/cnt
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= IDLE;
         r_cnt   <= '0;
         r_busy  <= 1'b0;
         r_zero  <= 1'b1;
         r_done  <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
         r_busy  <= (w_state_nxt == RUN);
         r_zero  <= (w_cnt_nxt == '0);
         r_done  <= w_done_nxt;
      end
   end

   assign cnt  = r_cnt;
   assign busy = r_busy;
   assign zero = r_zero;
   assign done = r_done;

endmodule
